// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC bus responder: register map, reset values,
// bus FSM states and BCD field limits.
package rtc_bus_pkg;

  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DATE  = 8'h24;
  localparam logic [7:0] ADDR_MONTH = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;
  localparam logic [7:0] ADDR_WDAY  = 8'h27;
  localparam logic [7:0] ADDR_WEEK  = 8'h28;
  localparam logic [7:0] ADDR_TMR0  = 8'h41;
  localparam logic [7:0] ADDR_TMR1  = 8'h42;
  localparam logic [7:0] ADDR_TMR2  = 8'h43;

  localparam logic [7:0] RST_ZERO  = 8'h00;
  localparam logic [7:0] RST_DATE  = 8'h01;
  localparam logic [7:0] RST_MONTH = 8'h01;
  localparam logic [7:0] RST_WDAY  = 8'h01;

  localparam logic [7:0] SEC_MIN  = 8'h00;
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MIN  = 8'h00;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MIN = 8'h00;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] WDAY_MIN = 8'h01;
  localparam logic [7:0] WDAY_MAX = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bcd_counter.sv
// Combinational BCD step for one time field: load beats increment; any value at
// or beyond max (including out-of-range BCD) wraps to min and raises carry.
module bcd_counter (
  input  logic [7:0] val_i,
  input  logic       inc_i,
  input  logic [7:0] max_i,
  input  logic [7:0] min_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] next_o,
  output logic       carry_o
);

  logic       wrap;
  logic [7:0] stepped;

  always_comb begin
    wrap = (val_i >= max_i);
    if (val_i[3:0] >= 4'd9) begin
      stepped = {val_i[7:4] + 4'd1, 4'd0};
    end else begin
      stepped = {val_i[7:4], val_i[3:0] + 4'd1};
    end
    // Carry depends only on the increment so a simultaneous load still ripples.
    carry_o = inc_i && wrap;
    if (load_i) begin
      next_o = load_val_i;
    end else if (inc_i) begin
      next_o = wrap ? min_i : stepped;
    end else begin
      next_o = val_i;
    end
  end

endmodule

// File: rtl/rtc_bus_responder.sv
// RTC chip side of the multiplexed address/data bus: strobe decode, BCD register file, seconds ticker.
// Writes commit 2 cycles after Write rises; read data drives 2 cycles after Read falls; no backpressure.
module rtc_bus_responder
  import rtc_bus_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       ChipSelect,
  input  logic       Read,
  input  logic       Write,
  input  logic       AoD,
  inout  wire  [7:0] DATA_ADDRESS,
  output logic       tick
);

  localparam logic [31:0] PRESC_LAST = 32'(TICKS_PER_SEC - 1);

  logic       cs_q, rd_q, wr_q, aod_q, wr_prev_q;
  logic [7:0] bus_q;
  bus_state_e state_q, state_d;
  logic [7:0] addr_q, dout_q, rd_mux;
  logic       oe_q;

  logic [31:0] presc_q;
  logic        tick_q;
  logic [7:0]  sec_q, min_q, hour_q, date_q, month_q, year_q, wday_q, week_q;
  logic [7:0]  tmr0_q, tmr1_q, tmr2_q;
  logic [7:0]  sec_d, min_d, hour_d, wday_d;
  logic        sec_carry, min_carry, hour_carry, wday_carry_unused;

  logic wr_rise, addr_commit, wr_commit, presc_wrap;
  logic ld_sec, ld_min, ld_hour, ld_wday;

  assign wr_rise     = wr_q && !wr_prev_q;
  assign addr_commit = (state_q == ST_ADDR)  && !cs_q && wr_rise;
  assign wr_commit   = (state_q == ST_WDATA) && !cs_q && wr_rise;
  assign presc_wrap  = (presc_q == PRESC_LAST);

  assign ld_sec  = wr_commit && (addr_q == ADDR_SEC);
  assign ld_min  = wr_commit && (addr_q == ADDR_MIN);
  assign ld_hour = wr_commit && (addr_q == ADDR_HOUR);
  assign ld_wday = wr_commit && (addr_q == ADDR_WDAY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!cs_q && !wr_q) begin
          state_d = aod_q ? ST_WDATA : ST_ADDR;
        end else if (!cs_q && !rd_q && aod_q) begin
          state_d = ST_RDATA;
        end
      end
      ST_ADDR, ST_WDATA: if (wr_rise) state_d = ST_IDLE;
      ST_RDATA:          if (rd_q)    state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
    // Deselect abandons whatever phase is in flight.
    if (cs_q) state_d = ST_IDLE;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (addr_q)
      ADDR_SEC:   rd_mux = sec_q;
      ADDR_MIN:   rd_mux = min_q;
      ADDR_HOUR:  rd_mux = hour_q;
      ADDR_DATE:  rd_mux = date_q;
      ADDR_MONTH: rd_mux = month_q;
      ADDR_YEAR:  rd_mux = year_q;
      ADDR_WDAY:  rd_mux = wday_q;
      ADDR_WEEK:  rd_mux = week_q;
      ADDR_TMR0:  rd_mux = tmr0_q;
      ADDR_TMR1:  rd_mux = tmr1_q;
      ADDR_TMR2:  rd_mux = tmr2_q;
      default:    rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      wr_prev_q <= 1'b1;
      aod_q     <= 1'b0;
      bus_q     <= 8'h00;
      state_q   <= ST_IDLE;
      addr_q    <= 8'h00;
      dout_q    <= 8'h00;
      oe_q      <= 1'b0;
    end else begin
      cs_q      <= ChipSelect;
      rd_q      <= Read;
      wr_q      <= Write;
      wr_prev_q <= wr_q;
      aod_q     <= AoD;
      bus_q     <= DATA_ADDRESS;
      state_q   <= state_d;
      oe_q      <= (state_d == ST_RDATA);
      dout_q    <= rd_mux;
      if (addr_commit) addr_q <= bus_q;
    end
  end

  bcd_counter u_sec (
    .val_i(sec_q), .inc_i(presc_wrap), .max_i(SEC_MAX), .min_i(SEC_MIN),
    .load_i(ld_sec), .load_val_i(bus_q), .next_o(sec_d), .carry_o(sec_carry)
  );
  bcd_counter u_min (
    .val_i(min_q), .inc_i(sec_carry), .max_i(MIN_MAX), .min_i(MIN_MIN),
    .load_i(ld_min), .load_val_i(bus_q), .next_o(min_d), .carry_o(min_carry)
  );
  bcd_counter u_hour (
    .val_i(hour_q), .inc_i(min_carry), .max_i(HOUR_MAX), .min_i(HOUR_MIN),
    .load_i(ld_hour), .load_val_i(bus_q), .next_o(hour_d), .carry_o(hour_carry)
  );
  bcd_counter u_wday (
    .val_i(wday_q), .inc_i(hour_carry), .max_i(WDAY_MAX), .min_i(WDAY_MIN),
    .load_i(ld_wday), .load_val_i(bus_q), .next_o(wday_d), .carry_o(wday_carry_unused)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      sec_q   <= RST_ZERO;
      min_q   <= RST_ZERO;
      hour_q  <= RST_ZERO;
      date_q  <= RST_DATE;
      month_q <= RST_MONTH;
      year_q  <= RST_ZERO;
      wday_q  <= RST_WDAY;
      week_q  <= RST_ZERO;
      tmr0_q  <= RST_ZERO;
      tmr1_q  <= RST_ZERO;
      tmr2_q  <= RST_ZERO;
    end else begin
      // Setting seconds restarts the second so it lasts a full period.
      presc_q <= (ld_sec || presc_wrap) ? '0 : presc_q + 32'd1;
      tick_q  <= presc_wrap;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      wday_q  <= wday_d;
      if (wr_commit && addr_q == ADDR_DATE)  date_q  <= bus_q;
      if (wr_commit && addr_q == ADDR_MONTH) month_q <= bus_q;
      if (wr_commit && addr_q == ADDR_YEAR)  year_q  <= bus_q;
      if (wr_commit && addr_q == ADDR_WEEK)  week_q  <= bus_q;
      if (wr_commit && addr_q == ADDR_TMR0)  tmr0_q  <= bus_q;
      if (wr_commit && addr_q == ADDR_TMR1)  tmr1_q  <= bus_q;
      if (wr_commit && addr_q == ADDR_TMR2)  tmr2_q  <= bus_q;
    end
  end

  assign tick         = tick_q;
  assign DATA_ADDRESS = oe_q ? dout_q : 8'hzz;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Self-checking bench for rtc_bus_responder: bus-level stimulus against a
// calendar-arithmetic reference model; the bus is pulled up so release reads 0xFF.
module tb_rtc_bus_responder;

  localparam int TPS = 10;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ChipSelect = 1'b1;
  logic       Read = 1'b1;
  logic       Write = 1'b1;
  logic       AoD = 1'b0;
  logic       tick;
  logic       drv_en = 1'b0;
  logic [7:0] drv_val = 8'h00;
  tri1  [7:0] DATA_ADDRESS;

  assign DATA_ADDRESS = drv_en ? drv_val : 8'hzz;

  int errs = 0;
  int checks = 0;

  rtc_bus_responder #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .Reset(Reset), .ChipSelect(ChipSelect), .Read(Read),
    .Write(Write), .AoD(AoD), .DATA_ADDRESS(DATA_ADDRESS), .tick(tick)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_regs [0:255];
  logic [7:0] m_addr, m_wdat, m_adat;
  bit         m_wpend = 0, m_apend = 0;
  int         m_cnt = 0;
  int         m_ticks = 0;
  int         dut_ticks = 0;

  function automatic bit is_mapped(input logic [7:0] a);
    return (a >= 8'h21 && a <= 8'h28) || (a >= 8'h41 && a <= 8'h43);
  endfunction

  function automatic logic [7:0] int2bcd(input int d);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  function automatic logic [7:0] step(input logic [7:0] v, input int maxd, input int mind, output bit c);
    int d;
    d = int'(v[7:4]) * 10 + int'(v[3:0]);
    c = (d >= maxd);
    return c ? int2bcd(mind) : int2bcd(d + 1);
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    return is_mapped(a) ? m_regs[a] : 8'h00;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
    m_regs[8'h24] = 8'h01;
    m_regs[8'h25] = 8'h01;
    m_regs[8'h27] = 8'h01;
    m_addr = 8'h00; m_cnt = 0; m_wpend = 0; m_apend = 0;
  endtask

  task automatic m_second();
    bit c;
    m_regs[8'h21] = step(m_regs[8'h21], 59, 0, c);
    if (c) m_regs[8'h22] = step(m_regs[8'h22], 59, 0, c);
    if (c) m_regs[8'h23] = step(m_regs[8'h23], 23, 0, c);
    if (c) m_regs[8'h27] = step(m_regs[8'h27], 7, 1, c);
  endtask

  always @(posedge clk) begin
    if (Reset) begin
      m_reset();
    end else begin
      bit wrap;
      wrap = (m_cnt == TPS - 1);
      if ((m_wpend && m_addr == 8'h21) || wrap) m_cnt = 0;
      else m_cnt = m_cnt + 1;
      if (wrap) begin
        m_ticks = m_ticks + 1;
        m_second();
      end
      if (m_wpend) begin
        if (is_mapped(m_addr)) m_regs[m_addr] = m_wdat;
        m_wpend = 0;
      end
      if (m_apend) begin
        m_addr = m_adat;
        m_apend = 0;
      end
    end
  end

  always @(negedge clk) if (tick === 1'b1) dut_ticks = dut_ticks + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- bus tasks ----------------
  task automatic bus_phase(input bit aod, input logic [7:0] val, input bit abort);
    @(negedge clk);
    ChipSelect = 1'b0; AoD = aod; Write = 1'b0; drv_en = 1'b1; drv_val = val;
    repeat (2) @(negedge clk);
    if (abort) begin
      ChipSelect = 1'b1;
      @(negedge clk);
    end
    Write = 1'b1;
    @(negedge clk);
    if (!abort) begin
      if (aod) begin m_wdat = val; m_wpend = 1; end
      else     begin m_adat = val; m_apend = 1; end
    end
    @(negedge clk);
    ChipSelect = 1'b1; AoD = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_phase(1'b0, a, 1'b0);
    bus_phase(1'b1, d, 1'b0);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] got,
                          output logic [7:0] exp, output logic [7:0] rel);
    bus_phase(1'b0, a, 1'b0);
    @(negedge clk);
    ChipSelect = 1'b0; AoD = 1'b1; Read = 1'b0;
    @(negedge clk);
    exp = m_read(m_addr);
    @(negedge clk);
    got = DATA_ADDRESS;
    repeat (2) @(negedge clk);
    Read = 1'b1;
    repeat (2) @(negedge clk);
    rel = DATA_ADDRESS;
    ChipSelect = 1'b1; AoD = 1'b0;
  endtask

  task automatic wait_tick(output int k);
    k = 0;
    for (int i = 1; i <= TPS + 2; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin k = i; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] got, exp, rel;
    logic [7:0] want [4] = '{8'h01, 8'h01, 8'h01, 8'h00};
    logic [7:0] addr [4] = '{8'h24, 8'h25, 8'h27, 8'h26};
    Reset = 1'b1;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    checks++; if (tick !== 1'b0) begin errs++; $display("FAIL reset_tick got=%b want=0", tick); end
    checks++; if (DATA_ADDRESS !== 8'hFF) begin errs++; $display("FAIL reset_bus_released got=%h want=ff", DATA_ADDRESS); end
    bus_read(8'h21, got, exp, rel);
    checks++; if (got !== 8'h00) begin errs++; $display("FAIL reset_sec got=%h want=00", got); end
    for (int i = 0; i < 4; i++) begin
      bus_read(addr[i], got, exp, rel);
      checks++;
      if (got !== want[i]) begin errs++; $display("FAIL reset_reg_%h got=%h want=%h", addr[i], got, want[i]); end
    end
  endtask

  task automatic test_minutes_write();
    logic [7:0] got, exp, rel;
    bus_write(8'h22, 8'h45);
    bus_read(8'h22, got, exp, rel);
    checks++; if (got !== 8'h45) begin errs++; $display("FAIL min_write got=%h want=45", got); end
    bus_read(8'h24, got, exp, rel);
    checks++; if (got !== 8'h01) begin errs++; $display("FAIL min_write_date got=%h want=01", got); end
    bus_read(8'h23, got, exp, rel);
    checks++; if (got !== exp) begin errs++; $display("FAIL min_write_hour got=%h want=%h", got, exp); end
  endtask

  task automatic test_unmapped();
    logic [7:0] got, exp, rel;
    bus_write(8'h30, 8'h77);
    bus_read(8'h30, got, exp, rel);
    checks++; if (got !== 8'h00) begin errs++; $display("FAIL unmapped_read got=%h want=00", got); end
    checks++; if (rel !== 8'hFF) begin errs++; $display("FAIL unmapped_release got=%h want=ff", rel); end
  endtask

  task automatic test_rollover();
    logic [7:0] got, exp, rel;
    int k;
    bus_write(8'h21, 8'h00);
    bus_write(8'h23, 8'h23);
    bus_write(8'h22, 8'h59);
    bus_write(8'h27, 8'h07);
    bus_write(8'h21, 8'h59);
    wait_tick(k);
    checks++; if (k != TPS) begin errs++; $display("FAIL rollover_tick_delay got=%0d want=%0d", k, TPS); end
    bus_read(8'h27, got, exp, rel);
    checks++; if (got !== 8'h01) begin errs++; $display("FAIL rollover_wday got=%h want=01", got); end
    bus_read(8'h23, got, exp, rel);
    checks++; if (got !== 8'h00) begin errs++; $display("FAIL rollover_hour got=%h want=00", got); end
    bus_read(8'h22, got, exp, rel);
    checks++; if (got !== 8'h00) begin errs++; $display("FAIL rollover_min got=%h want=00", got); end
    bus_read(8'h21, got, exp, rel);
    checks++; if (got !== exp) begin errs++; $display("FAIL rollover_sec got=%h want=%h", got, exp); end
  endtask

  task automatic test_write_tick_collision();
    logic [7:0] got, exp, rel;
    int k, guard;
    bus_phase(1'b0, 8'h21, 1'b0);
    guard = 0;
    while (m_cnt != TPS - 5 && guard < 4 * TPS) begin
      @(negedge clk);
      guard++;
    end
    // commit lands on the fourth edge after the phase starts: the wrap edge
    bus_phase(1'b1, 8'h30, 1'b0);
    checks++; if (tick !== 1'b1) begin errs++; $display("FAIL collide_tick got=%b want=1", tick); end
    wait_tick(k);
    checks++; if (k != TPS) begin errs++; $display("FAIL collide_presc_restart got=%0d want=%0d", k, TPS); end
    bus_read(8'h21, got, exp, rel);
    checks++; if (got !== 8'h31) begin errs++; $display("FAIL collide_sec got=%h want=31", got); end
  endtask

  task automatic test_bad_bcd();
    logic [7:0] got, exp, rel;
    int k;
    bus_write(8'h22, 8'h10);
    bus_write(8'h21, 8'h75);
    wait_tick(k);
    bus_read(8'h22, got, exp, rel);
    checks++; if (got !== 8'h11) begin errs++; $display("FAIL bad_bcd_carry got=%h want=11", got); end
    bus_read(8'h21, got, exp, rel);
    checks++; if (got !== exp) begin errs++; $display("FAIL bad_bcd_sec got=%h want=%h", got, exp); end
  endtask

  task automatic test_abort();
    logic [7:0] got, exp, rel;
    bus_write(8'h41, 8'h12);
    bus_phase(1'b1, 8'h99, 1'b1);
    bus_read(8'h41, got, exp, rel);
    checks++; if (got !== 8'h12) begin errs++; $display("FAIL abort_no_write got=%h want=12", got); end
    bus_write(8'h42, 8'h34);
    bus_read(8'h42, got, exp, rel);
    checks++; if (got !== 8'h34) begin errs++; $display("FAIL abort_recover got=%h want=34", got); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] got, exp, rel;
    bus_write(8'h24, 8'h15);
    bus_phase(1'b0, 8'h24, 1'b0);
    @(negedge clk);
    ChipSelect = 1'b0; AoD = 1'b1; Read = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (DATA_ADDRESS !== 8'h15) begin errs++; $display("FAIL midread_driven got=%h want=15", DATA_ADDRESS); end
    Reset = 1'b1;
    @(negedge clk);
    checks++; if (DATA_ADDRESS !== 8'hFF) begin errs++; $display("FAIL midread_release got=%h want=ff", DATA_ADDRESS); end
    Reset = 1'b0; Read = 1'b1; ChipSelect = 1'b1; AoD = 1'b0;
    bus_read(8'h21, got, exp, rel);
    checks++; if (got !== 8'h00) begin errs++; $display("FAIL midread_sec got=%h want=00", got); end
    bus_read(8'h24, got, exp, rel);
    checks++; if (got !== 8'h01) begin errs++; $display("FAIL midread_date got=%h want=01", got); end
  endtask

  task automatic test_random();
    logic [7:0] got, exp, rel, a, d;
    logic [7:0] tbl [14] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                             8'h28, 8'h41, 8'h42, 8'h43, 8'h30, 8'h00, 8'hFF};
    for (int i = 0; i < 25; i++) begin
      a = tbl[$urandom_range(0, 13)];
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : int2bcd($urandom_range(0, 59));
      if (a == 8'h21 || a == 8'h22 || a == 8'h23 || a == 8'h27) d = int2bcd($urandom_range(0, 59));
      bus_write(a, d);
      a = tbl[$urandom_range(0, 13)];
      bus_read(a, got, exp, rel);
      checks++;
      if (got !== exp) begin errs++; $display("FAIL random_read_%0d addr=%h got=%h want=%h", i, a, got, exp); end
    end
    @(negedge clk);
    checks++;
    if (dut_ticks != m_ticks) begin errs++; $display("FAIL tick_count got=%0d want=%0d", dut_ticks, m_ticks); end
  endtask

  initial begin
    test_reset();
    test_minutes_write();
    test_unmapped();
    test_rollover();
    test_write_tick_collision();
    test_bad_bcd();
    test_abort();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Synthesizable model of the RTC chip side of the multiplexed 8-bit address/data bus driven by the RTC protocol initiator. It decodes the ChipSelect/Read/Write/AoD strobes, latches the register address, accepts writes into a BCD timekeeping register file, drives read data back onto `DATA_ADDRESS`, and advances the clock registers from a prescaled tick. It sits opposite the initiator, on the board-model side of the bus, for closed-loop simulation and on-FPGA loopback of the time display path.

## Interface
- `TICKS_PER_SEC`, default 100_000_000: clk cycles per one-second tick.
- `clk`  in  1  system clock; all logic rising-edge.
- `Reset`  in  1  synchronous, active-high reset.
- `ChipSelect`  in  1  bus select, active-low.
- `Read`  in  1  read strobe, active-low.
- `Write`  in  1  write strobe, active-low.
- `AoD`  in  1  phase select: 0 = address phase, 1 = data phase.
- `DATA_ADDRESS`  inout  8  multiplexed bus; driven only during a read data phase, else high-Z.
- `tick`  out  1  one-cycle pulse on each seconds increment (bench observability).

## Operation
- Input stage: `ChipSelect`, `Read`, `Write`, `AoD`, `DATA_ADDRESS` registered once (`*_q`). All decoding uses the registered copies; a strobe edge means `*_q` versus its previous value.
- FSM states: IDLE, ADDR, WDATA, RDATA.
  - IDLE → ADDR: `cs_q`=0, `wr_q`=0, `aod_q`=0.
  - IDLE → WDATA: `cs_q`=0, `wr_q`=0, `aod_q`=1.
  - IDLE → RDATA: `cs_q`=0, `rd_q`=0, `aod_q`=1.
  - ADDR: on `wr_q` rising edge, latch the bus into `addr_reg`, then return to IDLE.
  - WDATA: on `wr_q` rising edge, write the bus to `reg[addr_reg]`, then return to IDLE.
  - RDATA: drive while `rd_q`=0; `rd_q`=1 → IDLE.
  - Any state: `cs_q`=1 → IDLE, with no latch or write. This is an abort.
- Register map, all BCD:
  - 0x21 seconds 00–59; 0x22 minutes 00–59; 0x23 hours 00–23.
  - 0x24 date; 0x25 month; 0x26 year; 0x27 weekday 1–7; 0x28 week number.
  - 0x41–0x43 timer registers, plain storage.
  - Other addresses: reads return 0x00, writes are ignored.
- Read data: `reg[addr_reg]` is registered into `dout`. `oe` is registered high while in RDATA.
- Timekeeping:
  - Prescaler counts 0..TICKS_PER_SEC-1. At wrap, it pulses `tick`.
  - On `tick`: seconds +1. 59→00 carries to minutes; minutes 59→00 carries to hours; hours 23→00 carries to weekday (7→1).
  - Date, month, year and week number never auto-increment.
- Simultaneous write and tick to the same register: the write wins and that register's increment is dropped. Carries already generated still propagate.
- A write to 0x21 also clears the prescaler.
- Out-of-range BCD written (e.g. 0x75 to seconds) is stored as-is. The next increment wraps it to 00 and carries.
- Reset values:
  - All registers 0x00, except date, month and weekday, which are 0x01.
  - `addr_reg` 0x00; prescaler 0; FSM IDLE; `oe` 0 (bus high-Z); `tick` 0; `dout` 0x00.
  - Reset mid-transaction abandons it with no write.

## Timing
- Strobe-to-internal latency is 1 cycle (input register). Edge detection adds 1 more cycle, so a write commits 2 cycles after the `Write` pin rises.
- Read: bus driven 2 cycles after `Read` falls with CS=0 and AoD=1. It is released (high-Z) 2 cycles after `Read` rises. The initiator must keep `Read` low at least 4 cycles.
- Min strobe width 2 cycles; shorter pulses may be missed.
- `tick` is asserted in the same cycle as the register update it causes.

## Structure
- Package `rtc_bus_pkg`:
  - Register address constants (`ADDR_SEC`…`ADDR_TMR2`).
  - Reset values.
  - FSM state enum.
  - BCD limits per field.
- Sub-module `bcd_counter`:
  - Ports: 8-bit BCD value, `inc`, `max`, `min`, `load`, `load_val`.
  - Outputs: next value and `carry`.
  - One instance each for seconds, minutes, hours and weekday.
- Tri-state at top: `DATA_ADDRESS = oe ? dout : 8'hzz`.

## Test plan
- Address phase 0x22 then write data 0x45 → minutes reads back 0x45; no other register changes.
- Write 0x59/0x59/0x23 to sec/min/hour with weekday 0x07, `TICKS_PER_SEC`=10 → after 10 cycles all read 0x00 and weekday 0x01; `tick` pulses once.
- Read of unmapped 0x30 → bus 0x00 during the data phase, then high-Z within 2 cycles of `Read` rising.
- Write to 0x21 in the exact cycle `tick` fires → seconds holds the written value; prescaler restarts at 0.
- `ChipSelect` deasserted before `Write` rises in the data phase → no register changes; FSM returns to IDLE.
- `Reset` asserted mid read → bus high-Z next cycle; registers at reset values (date 0x01, seconds 0x00).
